temp_poll_sched: RTL
====================

Name: temp_poll_sched

Overview:
- Sequencer that owns the I2C temperature master. It issues periodic or one-shot register reads, then detects completion from the master's state output.
- Each read is latched, screened for sensor error, and boxcar-averaged. The averaged value is compared against a fever threshold.
- Sits between the I2C master and the display/alarm logic; it is the only driver of the master's request inputs.

Parameters:
SLAVE_ADDR, 7'h5A, sensor I2C address
TEMP_REG, 8'h07, object-temperature register address
PERIOD_CYC, 1000000, clk cycles between automatic reads in run mode (>=16)
TIMEOUT_CYC, 4096, max cycles a transaction may take before abort
AVG_LOG2, 2, log2 of samples per average (0..4)
FEVER_THR, 16'd15533, raw threshold, 0.02 K/LSB (37.5 C)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
run  in  1  level; enables periodic polling
trig  in  1  one-cycle pulse; requests one read
err_clr  in  1  pulse; clears sticky error flags
i2c_en  out  1  request to master (held high for whole transaction)
i2c_wr_rd  out  1  constant 1 (read)
i2c_slave_addr  out  7  = SLAVE_ADDR
i2c_reg_addr  out  8  = TEMP_REG
i2c_data_wr  out  8  constant 0
i2c_data_rd  in  16  read data from master
i2c_state  in  8  master state; 0 = idle
temp_raw  out  16  last good sample
sample_valid  out  1  one-cycle pulse on new temp_raw
temp_avg  out  16  last average
avg_valid  out  1  one-cycle pulse on new temp_avg
fever  out  1  temp_avg >= FEVER_THR, updated with avg_valid
busy  out  1  high in any state except S_IDLE
err_timeout  out  1  sticky
err_sensor  out  1  sticky; sample with bit15 set
Decided: one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset: state S_IDLE; i2c_en, temp_raw, temp_avg, sample_valid, avg_valid, fever, busy, err_* = 0; accumulator, sample count, period counter and pending cleared.
- Period counter: counts only while run=1. When run=0 it holds at 0. On reaching PERIOD_CYC-1 it reloads to 0 and raises a request.
- Requests: trig or period expiry. If a request arrives while busy, set `pending` (depth 1; extra requests are dropped). Pending is consumed on the next return to S_IDLE.
- S_IDLE: on any request (trig, expiry, or pending) go to S_ISSUE next cycle.
- S_ISSUE: assert i2c_en; clear timeout counter; go to S_ACTIVE.
- S_ACTIVE: hold i2c_en. Wait for i2c_state != 0, then go to S_FINISH.
- S_FINISH: hold i2c_en. Wait for i2c_state == 0, then go to S_CAPTURE.
- Timeout: in S_ACTIVE/S_FINISH the timeout counter increments every cycle. At TIMEOUT_CYC-1, set err_timeout, drop i2c_en, go to S_RELEASE, and discard the sample.
- S_CAPTURE: drop i2c_en.
  - If i2c_data_rd[15]=1: set err_sensor; no update.
  - Else: temp_raw <= i2c_data_rd; pulse sample_valid; acc += data; cnt += 1.
- Averaging: when cnt reaches 2^AVG_LOG2 on this sample:
  - temp_avg <= (acc+data)>>AVG_LOG2, truncated.
  - avg_valid pulses 1 cycle after sample_valid; fever updates in the same cycle as avg_valid.
  - acc and cnt clear.
  - acc width 16+AVG_LOG2; no overflow possible.
- Capture then goes to S_RELEASE.
- S_RELEASE: i2c_en=0 for exactly 2 cycles (re-arms the master's one-shot), then go to S_IDLE.
- Latency: trig to i2c_en is 2 cycles. Completion (i2c_state back to 0) to sample_valid is 1 cycle.
- err_clr clears both sticky flags. If err_clr and a set condition occur in the same cycle, the set wins.
- run deasserted mid-transaction: the transaction completes normally; no new periodic requests follow.
- Reset mid-transaction: i2c_en drops immediately. The master freezes until its own reset; system reset covers both.

Decomposition:
- Shared package temp_pkg: state encoding (S_IDLE..S_RELEASE), MASTER_IDLE=8'd0, FEVER_THR default, and the raw-to-Kelvin scale constant.
- One sub-module: temp_avg_acc (accumulator, sample counter, divide, fever compare).
- The FSM, period counter and timeout counter remain in the top.

Test Plan:
- trig pulse; master model goes idle→1..8→0 after 300 cycles with data 16'h3A98 → i2c_en high 2 cycles after trig; temp_raw=16'h3A98; sample_valid 1 cycle after idle; i2c_en low 2 cycles after.
- run=1, PERIOD_CYC=100, AVG_LOG2=2, samples 15500, 15520, 15540, 15560 → temp_avg=15530, fever=0.
- Samples 15530, 15532, 15534, 15540 → avg 15534, fever=1 with avg_valid.
- Master never leaves idle → err_timeout after TIMEOUT_CYC; i2c_en dropped; no sample_valid; next trig still serviced.
- Data 16'h8000 → err_sensor=1; temp_raw unchanged; avg count not advanced. err_clr asserted simultaneously with a second error → flag stays 1.
- trig twice during a transaction → exactly one extra transaction runs; rst mid-S_FINISH → all outputs 0 next cycle.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature poll sequencer: FSM encoding,
// master idle code, default fever threshold and raw-to-kelvin scaling.
package temp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_FINISH  = 3'd3,
    S_CAPTURE = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [7:0]  MASTER_IDLE    = 8'd0;
  localparam logic [15:0] FEVER_THR_DEF  = 16'd15533;
  localparam int          RAW_MK_PER_LSB = 20;

  function automatic int raw_to_mk(input logic [15:0] raw);
    return 32'(raw) * RAW_MK_PER_LSB;
  endfunction

endpackage

// File: rtl/temp_avg_acc.sv
// Boxcar averager: sums 2^AVG_LOG2 good samples, emits the truncated mean
// one cycle after the last sample and compares it against the fever threshold.
module temp_avg_acc
  import temp_pkg::*;
#(
  parameter int          AVG_LOG2  = 2,
  parameter logic [15:0] FEVER_THR = FEVER_THR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  output logic [15:0] avg,
  output logic        avg_valid,
  output logic        fever
);

  localparam int AW = 16 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [AW-1:0]     acc_q, acc_d;
  logic [AVG_LOG2:0] cnt_q, cnt_d;
  logic [15:0]       avg_q, avg_d;
  logic              av_q, av_d;
  logic              fev_q, fev_d;
  logic [AW-1:0]     sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      av_q  <= 1'b0;
      fev_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      av_q  <= av_d;
      fev_q <= fev_d;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    av_d  = 1'b0;
    fev_d = fev_q;
    sum   = acc_q + AW'(smp_data);
    if (smp_valid) begin
      if (cnt_q == CNT_LAST) begin
        avg_d = 16'(sum >> AVG_LOG2);
        av_d  = 1'b1;
        fev_d = (avg_d >= FEVER_THR);
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign avg       = avg_q;
  assign avg_valid = av_q;
  assign fever     = fev_q;

endmodule

// File: rtl/temp_poll_sched.sv
// Sequencer owning the I2C temperature master: periodic/one-shot reads,
// completion detect, timeout abort, error screening and averaging.
//
// state     | meaning
// S_IDLE    | waiting for trig, period expiry or pending request
// S_ISSUE   | arm timeout, raise i2c_en next cycle
// S_ACTIVE  | i2c_en held, waiting for master to leave idle
// S_FINISH  | i2c_en held, waiting for master to return to idle
// S_CAPTURE | i2c_en low, sample latched and screened
// S_RELEASE | i2c_en low for two cycles to re-arm the master
module temp_poll_sched
  import temp_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h5A,
  parameter logic [7:0]  TEMP_REG    = 8'h07,
  parameter int          PERIOD_CYC  = 1000000,
  parameter int          TIMEOUT_CYC = 4096,
  parameter int          AVG_LOG2    = 2,
  parameter logic [15:0] FEVER_THR   = FEVER_THR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        trig,
  input  logic        err_clr,
  output logic        i2c_en,
  output logic        i2c_wr_rd,
  output logic [6:0]  i2c_slave_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_data_wr,
  input  logic [15:0] i2c_data_rd,
  input  logic [7:0]  i2c_state,
  output logic [15:0] temp_raw,
  output logic        sample_valid,
  output logic [15:0] temp_avg,
  output logic        avg_valid,
  output logic        fever,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_sensor
);

  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [PW-1:0] P_LOAD = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYC - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rel_q, rel_d;
  logic          pend_q, pend_d;
  logic          en_q, en_d;
  logic [15:0]   raw_q, raw_d;
  logic          sv_q, sv_d;
  logic          err_t_q, err_t_d;
  logic          err_s_q, err_s_d;

  logic per_exp, req_new, req_any, tmo_hit, waiting, timeout_evt, capture_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      per_q   <= P_LOAD;
      tmo_q   <= T_LOAD;
      rel_q   <= 1'b0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      raw_q   <= '0;
      sv_q    <= 1'b0;
      err_t_q <= 1'b0;
      err_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      rel_q   <= rel_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      raw_q   <= raw_d;
      sv_q    <= sv_d;
      err_t_q <= err_t_d;
      err_s_q <= err_s_d;
    end
  end

  // Timers are down-counters; a terminal count of zero marks expiry.
  assign per_exp = run && (per_q == '0);
  assign req_new = trig || per_exp;
  assign req_any = req_new || pend_q;
  assign tmo_hit = (tmo_q == '0);
  assign waiting = (state_q == S_ACTIVE) || (state_q == S_FINISH);

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    tmo_d   = tmo_q;
    rel_d   = 1'b0;
    pend_d  = pend_q;
    if (!run || per_q == '0) per_d = P_LOAD;
    else                     per_d = per_q - 1'b1;
    if (state_q == S_IDLE)      pend_d = 1'b0;
    else if (req_new)           pend_d = 1'b1;
    if (state_q == S_ISSUE)     tmo_d = T_LOAD;
    else if (waiting && !tmo_hit) tmo_d = tmo_q - 1'b1;
    unique case (state_q)
      S_IDLE:    if (req_any) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (tmo_hit)                        state_d = S_RELEASE;
        else if (i2c_state != MASTER_IDLE)  state_d = S_FINISH;
      end
      S_FINISH: begin
        if (tmo_hit)                        state_d = S_RELEASE;
        else if (i2c_state == MASTER_IDLE)  state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_RELEASE;
      S_RELEASE: begin
        rel_d = ~rel_q;
        if (rel_q) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Data is taken on the completion edge so sample_valid lands in S_CAPTURE.
  assign timeout_evt = waiting && tmo_hit;
  assign capture_evt = (state_q == S_FINISH) && !tmo_hit && (i2c_state == MASTER_IDLE);

  always_comb begin
    en_d    = (state_d == S_ACTIVE) || (state_d == S_FINISH);
    raw_d   = raw_q;
    sv_d    = 1'b0;
    if (capture_evt && !i2c_data_rd[15]) begin
      raw_d = i2c_data_rd;
      sv_d  = 1'b1;
    end
    err_s_d = (capture_evt && i2c_data_rd[15]) || (err_s_q && !err_clr);
    err_t_d = timeout_evt || (err_t_q && !err_clr);
  end

  temp_avg_acc #(
    .AVG_LOG2  (AVG_LOG2),
    .FEVER_THR (FEVER_THR)
  ) u_avg (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (sv_q),
    .smp_data  (raw_q),
    .avg       (temp_avg),
    .avg_valid (avg_valid),
    .fever     (fever)
  );

  assign i2c_en         = en_q;
  assign i2c_wr_rd      = 1'b1;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_reg_addr   = TEMP_REG;
  assign i2c_data_wr    = 8'h00;
  assign temp_raw       = raw_q;
  assign sample_valid   = sv_q;
  assign busy           = (state_q != S_IDLE);
  assign err_timeout    = err_t_q;
  assign err_sensor     = err_s_q;

endmodule
